// File: rtl/alu_operand_stage.sv
// Registered ALU operand stage: B-source select with immediate extension, valid/ready
// handshake and a 2-entry skid buffer. Optional operand forwarding under ALU_OPND_FWD_EN.
module alu_operand_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] reg_a,
    input  logic [DATA_W-1:0] reg_b,
    input  logic [IMM_W-1:0]  imm,
    input  logic              alu_src,
    input  logic [1:0]        ext_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b
`ifdef ALU_OPND_FWD_EN
    ,
    input  logic              fwd_valid,
    input  logic [1:0]        fwd_sel,
    input  logic [DATA_W-1:0] fwd_data
`endif
);

    generate
        if (DATA_W <= IMM_W) begin : g_bad_data_w
            $error("alu_operand_stage: DATA_W must be greater than IMM_W");
        end
        if (IMM_W < 2) begin : g_bad_imm_w
            $error("alu_operand_stage: IMM_W must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [DATA_W-1:0] skid_a;
    logic [DATA_W-1:0] skid_b;

    logic accept;
    logic consume;
    logic load_out;
    logic load_skid;
    logic pop_skid;

    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    // Mode 10 is a branch offset: the shifted-out top bit is simply dropped.
    always_comb begin
        imm_ext = imm_zext;
        case (ext_mode)
            2'b01:   imm_ext = imm_sext;
            2'b10:   imm_ext = {imm_sext[DATA_W-2:0], 1'b0};
            default: imm_ext = imm_zext;
        endcase
    end

    always_comb begin
        cap_a = reg_a;
        cap_b = alu_src ? imm_ext : reg_b;
`ifdef ALU_OPND_FWD_EN
        if (fwd_valid && fwd_sel[0]) begin
            cap_a = fwd_data;
        end
        if (fwd_valid && fwd_sel[1] && !alu_src) begin
            cap_b = fwd_data;
        end
`endif
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_BUSY;
                    load_out = 1'b1;
                end
            end
            ST_BUSY: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d  = ST_BUSY;
                    pop_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
        end else if (pop_skid) begin
            op_a <= skid_a;
            op_b <= skid_b;
        end else if (load_out) begin
            op_a <= cap_a;
            op_b <= cap_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_a <= '0;
            skid_b <= '0;
        end else if (load_skid) begin
            skid_a <= cap_a;
            skid_b <= cap_b;
        end else if (pop_skid) begin
            skid_a <= '0;
            skid_b <= '0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: driver pushes expected operands on accept,
// a negedge monitor pops and compares on every consume.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] reg_a;
    logic [15:0] reg_b;
    logic [3:0]  imm;
    logic        alu_src;
    logic [1:0]  ext_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
`ifdef ALU_OPND_FWD_EN
    logic        fwd_valid;
    logic [1:0]  fwd_sel;
    logic [15:0] fwd_data;
`endif

    alu_operand_stage #(.DATA_W(16), .IMM_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .imm       (imm),
        .alu_src   (alu_src),
        .ext_mode  (ext_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_a      (op_a),
        .op_b      (op_b)
`ifdef ALU_OPND_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_sel   (fwd_sel),
        .fwd_data  (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests    = 0;
    int unsigned failed   = 0;
    int unsigned consumed = 0;
    logic [31:0] exp_q[$];
    logic        rand_on  = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: extension computed as signed integer arithmetic, wrapped to 16 bits.
    function automatic logic [15:0] model_b(input logic src, input logic [1:0] mode,
                                            input logic [3:0] im, input logic [15:0] rb);
        int val;
        int sv;
        sv = (im >= 8) ? int'(im) - 16 : int'(im);
        if (!src) return rb;
        case (mode)
            2'd1:    val = sv;
            2'd2:    val = sv * 2;
            default: val = int'(im);
        endcase
        return 16'(val & 32'h0000_FFFF);
    endfunction

    task automatic scramble();
        reg_a    = 16'($urandom);
        reg_b    = 16'($urandom);
        imm      = 4'($urandom);
        alu_src  = 1'($urandom);
        ext_mode = 2'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic src,
                        input logic [1:0] mode, input logic [3:0] im,
                        input logic [15:0] exp_a, input logic [15:0] exp_b, output int waits);
        in_valid = 1'b1;
        reg_a    = a;
        reg_b    = b;
        alu_src  = src;
        ext_mode = mode;
        imm      = im;
        waits    = 0;
        while (!in_ready && waits < 1000) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            tests++;
            failed++;
            $display("FAIL accept_timeout: actual=in_ready 0 required=in_ready 1");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back({exp_a, exp_b});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 16'(exp_q.size()), 16'd0);
    endtask

    logic        stall_prev = 1'b0;
    logic [15:0] prev_a, prev_b;

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                check("hold_op_a", op_a, prev_a);
                check("hold_op_b", op_b, prev_b);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_beat: actual op_a=%h op_b=%h required=no beat", op_a, op_b);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_op_a", op_a, e[31:16]);
                    check("sb_op_b", op_b, e[15:0]);
                end
                consumed++;
            end
            stall_prev = out_valid && !out_ready;
            prev_a     = op_a;
            prev_b     = op_b;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_on) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int w;
        int unsigned mark;
        logic [15:0] ra, rb;
        logic        rs;
        logic [1:0]  rm;
        logic [3:0]  ri;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
`ifdef ALU_OPND_FWD_EN
        fwd_valid = 1'b0;
        fwd_sel   = 2'b00;
        fwd_data  = 16'h0000;
`endif
        scramble();
        repeat (4) begin
            @(posedge clk);
            #1;
            scramble();
            in_valid = 1'($urandom);
        end
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_op_a", op_a, 16'h0000);
        check("rst_op_b", op_b, 16'h0000);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        // Immediate extension
        send(16'h0001, 16'h5555, 1'b1, 2'b00, 4'b1000, 16'h0001, 16'h0008, w);
        send(16'h0002, 16'h5555, 1'b1, 2'b01, 4'b1000, 16'h0002, 16'hFFF8, w);
        send(16'h0003, 16'h5555, 1'b1, 2'b10, 4'b1000, 16'h0003, 16'hFFF0, w);
        send(16'h0004, 16'h5555, 1'b1, 2'b11, 4'b1000, 16'h0004, 16'h0008, w);
        send(16'h0005, 16'h5555, 1'b1, 2'b10, 4'b0111, 16'h0005, 16'h000E, w);
        drain();

        // Register path, one cycle latency
        send(16'hABCD, 16'h1234, 1'b0, 2'b01, 4'b1000, 16'hABCD, 16'h1234, w);
        check("reg_latency_valid", 16'(out_valid), 16'd1);
        check("reg_op_a", op_a, 16'hABCD);
        check("reg_op_b", op_b, 16'h1234);
        drain();

        // Backpressure into the skid buffer
        out_ready = 1'b0;
        send(16'h1111, 16'h0000, 1'b0, 2'b00, 4'h0, 16'h1111, 16'h0000, w);
        send(16'h2222, 16'h0000, 1'b0, 2'b00, 4'h0, 16'h2222, 16'h0000, w);
        check("bp_in_ready_low", 16'(in_ready), 16'd0);
        fork
            begin
                send(16'h3333, 16'h0000, 1'b0, 2'b00, 4'h0, 16'h3333, 16'h0000, w);
                check("bp_third_held", 16'(w > 0), 16'd1);
            end
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check("bp_stall_op_a", op_a, 16'h1111);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            ra = 16'h0100 + 16'(i);
            send(ra, ~ra, 1'b0, 2'b00, 4'h0, ra, ~ra, w);
            check("stream_no_wait", 16'(w), 16'd0);
            check("stream_valid", 16'(out_valid), 16'd1);
            check("stream_op_a", op_a, ra);
        end
        drain();

        // Mid-operation asynchronous reset from FULL
        out_ready = 1'b0;
        send(16'hAAAA, 16'h0000, 1'b0, 2'b00, 4'h0, 16'hAAAA, 16'h0000, w);
        send(16'hBBBB, 16'h0000, 1'b0, 2'b00, 4'h0, 16'hBBBB, 16'h0000, w);
        check("full_before_reset", 16'(in_ready), 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 16'(out_valid), 16'd0);
        check("async_rst_op_a", op_a, 16'h0000);
        check("async_rst_in_ready", 16'(in_ready), 16'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        mark      = consumed;
        send(16'h00FF, 16'h0000, 1'b0, 2'b00, 4'h0, 16'h00FF, 16'h0000, w);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_single_beat", 16'(consumed - mark), 16'd1);
        check("post_rst_idle", 16'(out_valid), 16'd0);

`ifdef ALU_OPND_FWD_EN
        fwd_valid = 1'b1;
        fwd_sel   = 2'b11;
        fwd_data  = 16'hBEEF;
        send(16'h1111, 16'h2222, 1'b0, 2'b00, 4'b1000, 16'hBEEF, 16'hBEEF, w);
        send(16'h1111, 16'h2222, 1'b1, 2'b01, 4'b1000, 16'hBEEF, 16'hFFF8, w);
        fwd_valid = 1'b0;
        drain();
`endif

        // Randomized traffic with random backpressure
        rand_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rm = 2'($urandom);
            ri = 4'($urandom);
            send(ra, rb, rs, rm, ri, ra, model_b(rs, rm, ri, rb), w);
        end
        rand_on = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised, registered successor to the ALU source mux.
- Selects operand B from either the register file or an extended immediate, and registers operands A and B.
- Sits between decode and the ALU, with a valid/ready handshake and a 2-entry skid buffer so decode stalls cleanly.
- Adds selectable immediate extension modes that the plain mux lacks.

Parameters:
- DATA_W, 16, operand width; must be greater than IMM_W.
- IMM_W, 4, immediate field width; must be at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents an operand set.
- in_ready  output  1  stage can accept; registered.
- reg_a  input  DATA_W  register-file operand A.
- reg_b  input  DATA_W  register-file operand B.
- imm  input  IMM_W  immediate field.
- alu_src  input  1  0: B = reg_b; 1: B = extended imm.
- ext_mode  input  2  immediate extension mode.
- out_valid  output  1  operands valid to the ALU.
- out_ready  input  1  ALU consumes.
- op_a  output  DATA_W  registered operand A.
- op_b  output  DATA_W  registered operand B.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values (applied immediately on rst_n falling, independent of clk):
  - out_valid=0, op_a=0, op_b=0, in_ready=1.
  - Skid entry invalid, skid data=0.
- Immediate extension (combinational, before capture):
  - ext_mode 00: zero-extend imm to DATA_W.
  - ext_mode 01: sign-extend from imm[IMM_W-1].
  - ext_mode 10: sign-extend, then shift left by 1; bit 0 = 0 and the top bit shifted out is discarded (branch offset).
  - ext_mode 11: reserved; behaves exactly as 00.
  - ext_mode is ignored when alu_src=0.
- Transfer rules:
  - Input accept = in_valid & in_ready.
  - Output consume = out_valid & out_ready.
  - Input fields are sampled only on accept.
- Latency: an accepted beat appears on op_a/op_b with out_valid=1 on the next clock edge when the stage is EMPTY.
- Buffer states:
  - EMPTY: out_valid=0, skid invalid.
  - BUSY: out_valid=1, skid invalid.
  - FULL: out_valid=1, skid valid, in_ready=0.
- Transitions:
  - EMPTY + accept -> BUSY; output register loaded.
  - BUSY + accept + consume -> BUSY; output register reloaded with the new beat.
  - BUSY + accept, no consume -> FULL; the beat goes to the skid register.
  - BUSY + consume, no accept -> EMPTY.
  - BUSY, no accept, no consume -> BUSY; held.
  - FULL + consume -> BUSY; skid moves to the output register, skid cleared. No accept is possible in FULL.
  - FULL, no consume -> FULL; all held.
- in_ready is registered and equals "next state != FULL".
- Ordering: beats leave in acceptance order; no beat is dropped or duplicated.
- Hold stability: op_a/op_b must not change while out_valid=1 and out_ready=0.
- Throughput: one beat per cycle sustained while out_ready=1.
- Reset mid-operation: any state returns to EMPTY immediately; buffered beats are discarded.

Optional Feature:
- Macro: ALU_OPND_FWD_EN.
- Defined: adds the following ports.
  - fwd_valid  input  1.
  - fwd_sel  input  2  bit0 targets A, bit1 targets B.
  - fwd_data  input  DATA_W.
- Forwarding rules (defined):
  - On accept with fwd_valid=1 and fwd_sel[0]=1, A is captured from fwd_data instead of reg_a.
  - On accept with fwd_valid=1, fwd_sel[1]=1 and alu_src=0, B is captured from fwd_data instead of reg_b.
  - When alu_src=1, fwd_sel[1] is ignored.
  - Forwarding is applied only at accept; beats already buffered are never modified.
- Not defined: these ports do not exist and capture uses reg_a/reg_b/imm only.

Test Plan (DATA_W=16, IMM_W=4):
- Reset: hold rst_n=0 with random inputs -> out_valid=0, op_a=0, op_b=0, in_ready=1. Assert rst_n=0 asynchronously between edges -> outputs clear without a clock edge.
- Extension, alu_src=1, imm=4'b1000, out_ready=1:
  - ext 00 -> op_b=16'h0008.
  - ext 01 -> op_b=16'hFFF8.
  - ext 10 -> op_b=16'hFFF0.
  - ext 11 -> op_b=16'h0008.
  - imm=4'b0111, ext 10 -> op_b=16'h000E.
- Register path: alu_src=0, reg_a=16'hABCD, reg_b=16'h1234, ext=01 -> op_a=16'hABCD, op_b=16'h1234 one cycle after accept.
- Backpressure: out_ready=0, present beats A=16'h1111, 16'h2222, 16'h3333 back to back:
  - First two accepted; in_ready=0 after the second accept; third held upstream.
  - op_a stays 16'h1111 while stalled.
  - Raise out_ready -> op_a sequence 1111, 2222, 3333, with no loss or repeat.
- Streaming: out_ready=1, 8 consecutive beats -> 8 consecutive cycles of out_valid=1, each one cycle after its accept, in_ready constantly 1.
- Mid-operation reset: reach FULL, then pulse rst_n=0 -> EMPTY, in_ready=1. After release, the next beat 16'h00FF emerges alone.
- Forwarding (ALU_OPND_FWD_EN defined): fwd_valid=1, fwd_sel=2'b11, fwd_data=16'hBEEF:
  - alu_src=0 -> op_a=op_b=16'hBEEF.
  - alu_src=1 -> op_a=16'hBEEF, op_b=extended imm.
